// File: rtl/cajero_cliente.sv
// Customer-side sequencer for the ATM controller: presents card, PIN digits, type and amount,
// then turns the controller's response flags into one registered result code per transaction.
module cajero_cliente #(
  parameter int DIG_GAP = 0,
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        REQ,
  input  logic [15:0] REQ_PIN,
  input  logic        REQ_TIPO,
  input  logic [31:0] REQ_MONTO,
  output logic        TARJETA_RECIBIDA,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        TIPO_TRANS,
  output logic        TIPO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  input  logic        BALANCE_ACTUALIZADO,
  input  logic        ENTREGAR_DINERO,
  input  logic        FONDOS_INSUFICIENTES,
  input  logic        PIN_INCORRECTO,
  input  logic        ADVERTENCIA,
  input  logic        Bloqueo,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  RESULT,
  output logic        ADV_VISTA
);

  // state | meaning: IDLE wait REQ | CARD card shown | DIG digit strobe | GAP inter-digit pause
  //                  PIN_CHK type strobe, PIN verdict | MONTO amount held for response | FIN DONE pulse
  typedef enum logic [2:0] {S_IDLE, S_CARD, S_DIG, S_GAP, S_PIN_CHK, S_MONTO, S_FIN} state_t;

  localparam logic [7:0] GAP_LAST = (DIG_GAP > 0) ? 8'(DIG_GAP - 1) : 8'd0;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state, w_nstate;
  logic [1:0]  r_idx, w_idx;
  logic [7:0]  r_cnt, w_cnt;
  logic [7:0]  r_gap, w_gap;
  logic [2:0]  r_result, w_result;
  logic        r_adv, w_adv;
  logic        w_accept;
  logic [15:0] r_pin;
  logic        r_tipo;
  logic [31:0] r_monto;
  logic        r_tarjeta, r_dig_stb, r_tipo_o, r_tipo_stb, r_monto_stb, r_busy, r_done;
  logic [3:0]  r_digito;
  logic [31:0] r_monto_o;
  logic        w_in_txn;

  assign w_in_txn = (r_state != S_IDLE) && (r_state != S_FIN);

  always_comb begin
    w_nstate = r_state;
    w_idx    = r_idx;
    w_cnt    = r_cnt;
    w_gap    = r_gap;
    w_result = r_result;
    w_adv    = r_adv | ((r_state != S_IDLE) & ADVERTENCIA);
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (REQ) begin
        w_accept = 1'b1;
        w_adv    = 1'b0;
        w_idx    = 2'd0;
        w_nstate = S_CARD;
      end
      S_CARD: w_nstate = S_DIG;
      S_DIG: begin
        if (r_idx == 2'd3) begin
          w_nstate = S_PIN_CHK;
        end else begin
          w_idx = r_idx + 2'd1;
          if (DIG_GAP > 0) begin
            w_nstate = S_GAP;
            w_gap    = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        if (r_gap == 8'd0) w_nstate = S_DIG;
        else               w_gap    = r_gap - 8'd1;
      end
      S_PIN_CHK: begin
        if (PIN_INCORRECTO) begin
          w_result = 3'd3;
          w_nstate = S_FIN;
        end else begin
          w_cnt    = 8'd0;
          w_nstate = S_MONTO;
        end
      end
      S_MONTO: begin
        if (BALANCE_ACTUALIZADO) begin
          w_result = ENTREGAR_DINERO ? 3'd1 : 3'd0;
          w_nstate = S_FIN;
        end else if (FONDOS_INSUFICIENTES) begin
          w_result = 3'd2;
          w_nstate = S_FIN;
        end else if (r_cnt == TO_LAST) begin
          w_result = 3'd5;
          w_nstate = S_FIN;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_FIN:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    // a lockout overrides whatever else the controller reported this cycle
    if (w_in_txn && Bloqueo) begin
      w_result = 3'd4;
      w_nstate = S_FIN;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 8'd0;
      r_gap       <= 8'd0;
      r_result    <= 3'd0;
      r_adv       <= 1'b0;
      r_pin       <= 16'd0;
      r_tipo      <= 1'b0;
      r_monto     <= 32'd0;
      r_tarjeta   <= 1'b0;
      r_digito    <= 4'd0;
      r_dig_stb   <= 1'b0;
      r_tipo_o    <= 1'b0;
      r_tipo_stb  <= 1'b0;
      r_monto_o   <= 32'd0;
      r_monto_stb <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_gap    <= w_gap;
      r_result <= w_result;
      r_adv    <= w_adv;
      if (w_accept) begin
        r_pin   <= REQ_PIN;
        r_tipo  <= REQ_TIPO;
        r_monto <= REQ_MONTO;
      end
      // outputs are registered from the state being entered
      r_tarjeta   <= (w_nstate != S_IDLE) && (w_nstate != S_FIN);
      r_busy      <= (w_nstate != S_IDLE);
      r_dig_stb   <= (w_nstate == S_DIG);
      if (w_nstate == S_DIG) r_digito <= r_pin[{w_idx, 2'b00} +: 4];
      r_tipo_stb  <= (w_nstate == S_PIN_CHK);
      if (w_nstate == S_PIN_CHK) r_tipo_o <= r_tipo;
      r_monto_stb <= (w_nstate == S_MONTO);
      if (w_nstate == S_MONTO) r_monto_o <= r_monto;
      r_done      <= (w_nstate == S_FIN);
    end
  end

  assign TARJETA_RECIBIDA = r_tarjeta;
  assign DIGITO           = r_digito;
  assign DIGITO_STB       = r_dig_stb;
  assign TIPO_TRANS       = r_tipo_o;
  assign TIPO_STB         = r_tipo_stb;
  assign MONTO            = r_monto_o;
  assign MONTO_STB        = r_monto_stb;
  assign BUSY             = r_busy;
  assign DONE             = r_done;
  assign RESULT           = r_result;
  assign ADV_VISTA        = r_adv;

endmodule

// File: tb/tb_cajero_cliente.sv
// Bench for cajero_cliente: a behavioural ATM model answers the sequencer, a queue scoreboard
// checks every DONE result, and per-scenario tasks check cycle timing and side effects.
module tb_cajero_cliente;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0, req1 = 1'b0;
  logic [15:0] pin = 16'h0;
  logic        tipo = 1'b0;
  logic [31:0] monto = 32'h0;

  logic        tarjeta, dstb, tipo_o, tstb, mstb, busy, done, adv;
  logic [3:0]  digito;
  logic [31:0] monto_o;
  logic [2:0]  result;
  logic        bal, entregar, fondos, pin_inc, advert, bloq;

  logic        tarjeta1, dstb1, tipo_o1, tstb1, mstb1, busy1, done1, adv1;
  logic [3:0]  digito1;
  logic [31:0] monto_o1;
  logic [2:0]  result1;
  logic        zero = 1'b0;

  cajero_cliente dut (
    .Clk(clk), .Reset(rst), .REQ(req), .REQ_PIN(pin), .REQ_TIPO(tipo), .REQ_MONTO(monto),
    .TARJETA_RECIBIDA(tarjeta), .DIGITO(digito), .DIGITO_STB(dstb), .TIPO_TRANS(tipo_o),
    .TIPO_STB(tstb), .MONTO(monto_o), .MONTO_STB(mstb),
    .BALANCE_ACTUALIZADO(bal), .ENTREGAR_DINERO(entregar), .FONDOS_INSUFICIENTES(fondos),
    .PIN_INCORRECTO(pin_inc), .ADVERTENCIA(advert), .Bloqueo(bloq),
    .BUSY(busy), .DONE(done), .RESULT(result), .ADV_VISTA(adv));

  cajero_cliente #(.DIG_GAP(2), .TIMEOUT(16)) dut_gap (
    .Clk(clk), .Reset(rst), .REQ(req1), .REQ_PIN(pin), .REQ_TIPO(tipo), .REQ_MONTO(monto),
    .TARJETA_RECIBIDA(tarjeta1), .DIGITO(digito1), .DIGITO_STB(dstb1), .TIPO_TRANS(tipo_o1),
    .TIPO_STB(tstb1), .MONTO(monto_o1), .MONTO_STB(mstb1),
    .BALANCE_ACTUALIZADO(mstb1), .ENTREGAR_DINERO(zero), .FONDOS_INSUFICIENTES(zero),
    .PIN_INCORRECTO(zero), .ADVERTENCIA(zero), .Bloqueo(zero),
    .BUSY(busy1), .DONE(done1), .RESULT(result1), .ADV_VISTA(adv1));

  // behavioural ATM: PIN 0x4321, locks after three wrong PINs, answers in the strobe cycle
  logic [31:0] atm_bal = 32'd0;
  logic [15:0] atm_entered = 16'h0;
  int          atm_fails = 0;
  logic        atm_tipo = 1'b0;
  logic        silent = 1'b0;
  logic        pin_ok;

  assign pin_ok   = (atm_entered == 16'h4321);
  assign pin_inc  = tstb && !pin_ok;
  assign bloq     = (atm_fails >= 3) && tarjeta;
  assign advert   = (atm_fails == 2) && tarjeta;
  assign fondos   = mstb && !silent && pin_ok && atm_tipo && (monto_o > atm_bal);
  assign bal      = mstb && !silent && pin_ok && !(atm_tipo && (monto_o > atm_bal));
  assign entregar = bal && atm_tipo;

  always @(posedge clk) begin
    if (dstb) atm_entered <= {digito, atm_entered[15:4]};
    if (tstb) atm_tipo <= tipo_o;
    if (pin_inc) atm_fails <= atm_fails + 1;
    if (bal) atm_bal <= atm_tipo ? atm_bal - monto_o : atm_bal + monto_o;
  end

  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done got result=%0d expected no DONE", result);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL sb_result got=%0d expected=%0d", result, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

  int dc, fd, nd, nt, nm;
  logic [15:0] dg;
  logic se, ad, ta;

  // drives one transaction on dut; cycle n = value visible after the n-th edge following REQ sampling
  task automatic run_txn(input logic [15:0] p, input logic t, input logic [31:0] m,
                         input logic [2:0] exp, input int busy_pulse);
    @(negedge clk);
    pin = p; tipo = t; monto = m; req = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req = 1'b0;
    dc = -1; fd = -1; nd = 0; nt = 0; nm = 0; dg = 16'h0; se = 1'b0; ad = 1'b0; ta = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      if (dstb) begin
        if (fd < 0) fd = n;
        dg = {digito, dg[15:4]};
        nd++;
      end
      if (tstb) nt++;
      if (mstb) nm++;
      if (entregar) se = 1'b1;
      if (done) begin
        dc = n; ad = adv; ta = tarjeta;
        break;
      end
      if (n == busy_pulse) begin
        req = 1'b1; pin = 16'h1111;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (dc < 0) begin
      total++; bad++;
      $display("FAIL txn_no_done got=none expected=DONE within 80 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({tarjeta, digito, dstb, tipo_o, tstb, monto_o, mstb, busy, done, result, adv} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%0b result=%0d expected all zero", busy, result);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle got busy=%0b expected=0", busy); end
  endtask

  task automatic test_deposit();
    run_txn(16'h4321, 1'b0, 32'd500, 3'd0, 0);
    total++; if (dc !== 8) begin bad++; $display("FAIL dep_done_cycle got=%0d expected=8", dc); end
    total++; if (fd !== 2 || nd !== 4) begin bad++; $display("FAIL dep_digit_timing got first=%0d n=%0d expected first=2 n=4", fd, nd); end
    total++; if (dg !== 16'h4321) begin bad++; $display("FAIL dep_digits got=%h expected=4321", dg); end
    total++; if (nt !== 1 || nm !== 1) begin bad++; $display("FAIL dep_strobes got tipo=%0d monto=%0d expected 1 1", nt, nm); end
    total++; if (atm_bal !== 32'd500) begin bad++; $display("FAIL dep_balance got=%0d expected=500", atm_bal); end
  endtask

  task automatic test_withdraw();
    run_txn(16'h4321, 1'b1, 32'd200, 3'd1, 0);
    total++; if (se !== 1'b1) begin bad++; $display("FAIL wd_entregar got=%0b expected=1", se); end
    total++; if (atm_bal !== 32'd300) begin bad++; $display("FAIL wd_balance got=%0d expected=300", atm_bal); end
    run_txn(16'h4321, 1'b1, 32'd1000, 3'd2, 0);
    total++; if (se !== 1'b0 || atm_bal !== 32'd300) begin bad++; $display("FAIL insuf got ent=%0b bal=%0d expected ent=0 bal=300", se, atm_bal); end
  endtask

  task automatic test_busy_req();
    int busy_seen;
    busy_seen = 0;
    run_txn(16'h4321, 1'b0, 32'd0, 3'd0, 4);
    total++; if (dc !== 8) begin bad++; $display("FAIL busyreq_done_cycle got=%0d expected=8", dc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL busyreq_ignored got busy_cycles=%0d expected=0", busy_seen); end
  endtask

  task automatic test_timeout();
    silent = 1'b1;
    run_txn(16'h4321, 1'b0, 32'd77, 3'd5, 0);
    silent = 1'b0;
    total++; if (nm !== 16) begin bad++; $display("FAIL to_monto_stb got=%0d expected=16", nm); end
    total++; if (dc !== 23 || ta !== 1'b0) begin bad++; $display("FAIL to_done got cycle=%0d tarjeta=%0b expected 23 0", dc, ta); end
    total++; if (atm_bal !== 32'd300) begin bad++; $display("FAIL to_balance got=%0d expected=300", atm_bal); end
  endtask

  task automatic test_reset_abort();
    int bad_cycles;
    bad_cycles = 0;
    @(negedge clk);
    pin = 16'h4321; tipo = 1'b0; monto = 32'd9; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    total++; if (dstb !== 1'b1) begin bad++; $display("FAIL abort_in_dig got dstb=%0b expected=1", dstb); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tarjeta, digito, dstb, tipo_o, tstb, monto_o, mstb, busy, done, result, adv} !== '0) begin
      bad++; $display("FAIL abort_outputs got busy=%0b dstb=%0b digito=%0d expected all zero", busy, dstb, digito);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad_cycles++;
    end
    total++; if (bad_cycles !== 0) begin bad++; $display("FAIL abort_quiet got active_cycles=%0d expected=0", bad_cycles); end
  endtask

  task automatic test_wrong_pin();
    for (int k = 1; k <= 3; k++) begin
      run_txn(16'h1111, 1'b0, 32'd100, 3'd3, 0);
      total++; if (dc !== 7 || nm !== 0) begin bad++; $display("FAIL pin_err_%0d got cycle=%0d monto_stb=%0d expected 7 0", k, dc, nm); end
      total++; if (ad !== (k == 3)) begin bad++; $display("FAIL pin_adv_%0d got=%0b expected=%0b", k, ad, (k == 3)); end
    end
  endtask

  task automatic test_locked();
    run_txn(16'h1111, 1'b1, 32'd100, 3'd4, 0);
    total++; if (dc !== 2) begin bad++; $display("FAIL lock_done_cycle got=%0d expected=2", dc); end
    total++; if (nt !== 0 || nd !== 0) begin bad++; $display("FAIL lock_no_strobes got tipo=%0d dig=%0d expected 0 0", nt, nd); end
    total++; if (ad !== 1'b0) begin bad++; $display("FAIL lock_adv_cleared got=%0b expected=0", ad); end
  endtask

  task automatic test_gap();
    int stb_cyc[$];
    int exp_cyc[4];
    int done_c;
    logic [15:0] digs;
    logic hold_ok;
    exp_cyc = '{2, 5, 8, 11};
    done_c = -1; digs = 16'h0; hold_ok = 1'b1;
    @(negedge clk);
    pin = 16'h8765; tipo = 1'b0; monto = 32'd3; req1 = 1'b1;
    @(posedge clk); #1; req1 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (dstb1) begin stb_cyc.push_back(n); digs = {digito1, digs[15:4]}; end
      if (n == 3 && digito1 !== 4'd5) hold_ok = 1'b0;
      if (done1) begin done_c = n; break; end
      @(posedge clk); #1;
    end
    total++;
    if (stb_cyc.size() != 4 || stb_cyc[0] != exp_cyc[0] || stb_cyc[1] != exp_cyc[1] ||
        stb_cyc[2] != exp_cyc[2] || stb_cyc[3] != exp_cyc[3]) begin
      bad++; $display("FAIL gap_strobe_cycles got n=%0d expected cycles 2 5 8 11", stb_cyc.size());
    end
    total++; if (digs !== 16'h8765 || !hold_ok) begin bad++; $display("FAIL gap_digits got=%h hold=%0b expected=8765 1", digs, hold_ok); end
    total++; if (done_c !== 14 || result1 !== 3'd0) begin bad++; $display("FAIL gap_done got cycle=%0d result=%0d expected 14 0", done_c, result1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_busy_req();
    test_timeout();
    test_reset_abort();
    test_wrong_pin();
    test_locked();
    test_gap();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d expected=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
